// File: rtl/ca_ps_sequencer_pkg.sv
// Shared types for the CA supply sequencer: state and fault-cause encodings.
package rpsc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FAN_SPINUP = 3'd1,
    G1_WAIT    = 3'd2,
    CA_RAMP    = 3'd3,
    RUN        = 3'd4,
    SHUTDOWN   = 3'd5,
    FAULT      = 3'd6
  } seq_state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    ALARM = 3'd1,
    FAN   = 3'd2,
    G1    = 3'd3,
    CA    = 3'd4
  } fault_e;

  localparam int unsigned RETRY_W = 2;

  // Supply-side faults may be retried; an interlock alarm never is.
  function automatic logic is_retryable(input fault_e code);
    return (code == FAN) || (code == G1) || (code == CA);
  endfunction

endpackage

// File: rtl/ca_ps_sequencer_if.sv
// Command, feedback and status bundle between the operator side and the CA sequencer.
interface ca_ps_sequencer_if;
  import rpsc_seq_pkg::*;

  logic                 start_req;
  logic                 stop_req;
  logic                 fault_clr;
  logic                 not_alarm;
  logic                 fan_ok;
  logic                 g1_ok;
  logic                 ca_ok;
  logic                 fan_on;
  logic                 g1_en;
  logic                 ca_ps_act;
  logic                 running;
  logic                 fault;
  fault_e               fault_code;
  seq_state_e           state;
  logic [RETRY_W-1:0]   retry_cnt;

  modport master (
    output start_req, stop_req, fault_clr, not_alarm, fan_ok, g1_ok, ca_ok,
    input  fan_on, g1_en, ca_ps_act, running, fault, fault_code, state, retry_cnt
  );

  modport slave (
    input  start_req, stop_req, fault_clr, not_alarm, fan_ok, g1_ok, ca_ok,
    output fan_on, g1_en, ca_ps_act, running, fault, fault_code, state, retry_cnt
  );

endinterface

// File: rtl/ca_ps_sequencer_timer.sv
// seq_timer: loadable down-counter shared by all sequencer phases; holds at zero.
module seq_timer #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ca_ps_sequencer.sv
// CA supply power sequencer: fan -> G1 -> CA PS with phase supervision and first-fault latch.
// Optional auto-retry of supply faults is enabled by defining RPSC_AUTO_RETRY_EN.
module ca_ps_sequencer
  import rpsc_seq_pkg::*;
#(
  parameter int unsigned FAN_SPINUP_CYC = 256,
  parameter int unsigned G1_TIMEOUT_CYC = 128,
  parameter int unsigned CA_SETTLE_CYC  = 3840,
  parameter int unsigned COOLDOWN_CYC   = 512,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned CNT_W          = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  ca_ps_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] FAN_LD  = CNT_W'(FAN_SPINUP_CYC - 1);
  localparam logic [CNT_W-1:0] G1_LD   = CNT_W'(G1_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CA_LD   = CNT_W'(CA_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYC - 1);

  if (RETRY_MAX > 3) begin : g_retry_range
    $error("RETRY_MAX does not fit retry_cnt");
  end

  seq_state_e         state_q, state_d;
  fault_e             code_q, code_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fan_q, fan_d, g1_q, g1_d, ca_q, ca_d, run_q, run_d, fault_q, fault_d;
  logic               tmr_load_s, tmr_expired_s, active_s;
  logic [CNT_W-1:0]   tmr_val_s;

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expired_o  (tmr_expired_s)
  );

  assign active_s = (state_q == FAN_SPINUP) || (state_q == G1_WAIT) || (state_q == CA_RAMP) ||
                    (state_q == RUN) || (state_q == SHUTDOWN);

  // Next state and fault cause; alarm outranks stop, which outranks the phase rules.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (active_s && !bus.not_alarm) begin
      state_d = FAULT;
      code_d  = ALARM;
    end else if (active_s && bus.stop_req && (state_q != SHUTDOWN)) begin
      state_d = SHUTDOWN;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_req && bus.not_alarm) begin
            state_d = FAN_SPINUP;
          end else if (bus.start_req) begin
            state_d = FAULT;
            code_d  = ALARM;
          end else begin
            state_d = IDLE;
          end
        end
        FAN_SPINUP: begin
          if (tmr_expired_s && bus.fan_ok) begin
            state_d = G1_WAIT;
          end else if (tmr_expired_s) begin
            state_d = FAULT;
            code_d  = FAN;
          end else begin
            state_d = FAN_SPINUP;
          end
        end
        G1_WAIT: begin
          if (bus.g1_ok) begin
            state_d = CA_RAMP;
          end else if (tmr_expired_s) begin
            state_d = FAULT;
            code_d  = G1;
          end else begin
            state_d = G1_WAIT;
          end
        end
        CA_RAMP: begin
          if (tmr_expired_s && bus.ca_ok) begin
            state_d = RUN;
          end else if (tmr_expired_s) begin
            state_d = FAULT;
            code_d  = CA;
          end else begin
            state_d = CA_RAMP;
          end
        end
        RUN: begin
          if (!bus.ca_ok) begin
            state_d = FAULT;
            code_d  = CA;
          end else begin
            state_d = RUN;
          end
        end
        SHUTDOWN: begin
          if (tmr_expired_s) begin
            state_d = IDLE;
          end else begin
            state_d = SHUTDOWN;
          end
        end
        FAULT: begin
          if (bus.fault_clr && bus.not_alarm && tmr_expired_s) begin
            state_d = IDLE;
            code_d  = NONE;
          end
`ifdef RPSC_AUTO_RETRY_EN
          else if (tmr_expired_s && bus.not_alarm && is_retryable(code_q) &&
                   (retry_q < RETRY_W'(RETRY_MAX))) begin
            state_d = FAN_SPINUP;
            code_d  = NONE;
          end
`endif
          else begin
            state_d = FAULT;
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = NONE;
        end
      endcase
    end
  end

  // Retry bookkeeping: counts re-entries from FAULT, cleared by RUN or operator acknowledge.
  always_comb begin
    retry_d = {RETRY_W{1'b0}};
`ifdef RPSC_AUTO_RETRY_EN
    if (bus.fault_clr || ((state_d == RUN) && (state_q != RUN))) begin
      retry_d = {RETRY_W{1'b0}};
    end else if ((state_q == FAULT) && (state_d == FAN_SPINUP)) begin
      retry_d = retry_q + {{(RETRY_W-1){1'b0}}, 1'b1};
    end else begin
      retry_d = retry_q;
    end
`endif
  end

  // Timer reload on every phase entry, and output decode from the next state.
  always_comb begin
    tmr_load_s = (state_d != state_q);
    tmr_val_s  = {CNT_W{1'b0}};
    fan_d      = 1'b0;
    g1_d       = 1'b0;
    ca_d       = 1'b0;
    run_d      = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      IDLE: begin
        tmr_val_s = {CNT_W{1'b0}};
      end
      FAN_SPINUP: begin
        tmr_val_s = FAN_LD;
        fan_d     = 1'b1;
      end
      G1_WAIT: begin
        tmr_val_s = G1_LD;
        fan_d     = 1'b1;
        g1_d      = 1'b1;
      end
      CA_RAMP: begin
        tmr_val_s = CA_LD;
        fan_d     = 1'b1;
        g1_d      = 1'b1;
        ca_d      = 1'b1;
      end
      RUN: begin
        fan_d     = 1'b1;
        g1_d      = 1'b1;
        ca_d      = 1'b1;
        run_d     = 1'b1;
      end
      SHUTDOWN: begin
        tmr_val_s = COOL_LD;
        fan_d     = 1'b1;
      end
      FAULT: begin
        tmr_val_s = COOL_LD;
        fan_d     = !((state_q == FAULT) && tmr_expired_s);
        fault_d   = 1'b1;
      end
      default: begin
        tmr_val_s = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= NONE;
      retry_q <= {RETRY_W{1'b0}};
      fan_q   <= 1'b0;
      g1_q    <= 1'b0;
      ca_q    <= 1'b0;
      run_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      retry_q <= retry_d;
      fan_q   <= fan_d;
      g1_q    <= g1_d;
      ca_q    <= ca_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fan_on     = fan_q;
  assign bus.g1_en      = g1_q;
  assign bus.ca_ps_act  = ca_q;
  assign bus.running    = run_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_ca_ps_sequencer.sv
// Bench for ca_ps_sequencer: phase/elapsed-cycle reference model plus directed literal checks.
module tb_ca_ps_sequencer;
  import rpsc_seq_pkg::*;

  localparam int P_FAN  = 4;
  localparam int P_G1   = 3;
  localparam int P_CA   = 6;
  localparam int P_COOL = 5;

  typedef struct packed {
    seq_state_e  ph;
    logic [15:0] el;
    fault_e      code;
    logic [1:0]  retry;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  mstate_t m;

  ca_ps_sequencer_if bus ();

  ca_ps_sequencer #(
    .FAN_SPINUP_CYC (P_FAN),
    .G1_TIMEOUT_CYC (P_G1),
    .CA_SETTLE_CYC  (P_CA),
    .COOLDOWN_CYC   (P_COOL),
    .RETRY_MAX      (3),
    .CNT_W          (13)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic mstate_t enter(input seq_state_e ph, input fault_e code, input logic [1:0] r);
    mstate_t n;
    n.ph = ph; n.el = 16'd0; n.code = code; n.retry = r;
    return n;
  endfunction

  // One clock of the sequencing rules, expressed as phase + cycles spent in phase.
  function automatic mstate_t m_step(input mstate_t s, input logic start, input logic stop,
                                     input logic clr, input logic na, input logic fok,
                                     input logic gok, input logic cok);
    mstate_t n;
    n = s;
    if (s.el != 16'hFFFF) n.el = s.el + 16'd1;
    case (s.ph)
      IDLE: begin
        if (start && na) n = enter(FAN_SPINUP, NONE, s.retry);
        else if (start) n = enter(FAULT, ALARM, s.retry);
      end
      FAULT: begin
        if (clr && na && (s.el >= P_COOL - 1)) n = enter(IDLE, NONE, s.retry);
`ifdef RPSC_AUTO_RETRY_EN
        else if ((s.el >= P_COOL - 1) && na && (s.code inside {FAN, G1, CA}) && (s.retry < 2'd3))
          n = enter(FAN_SPINUP, NONE, 2'(s.retry + 2'd1));
`endif
      end
      default: begin
        if (!na) n = enter(FAULT, ALARM, s.retry);
        else if (stop && (s.ph != SHUTDOWN)) n = enter(SHUTDOWN, NONE, s.retry);
        else begin
          case (s.ph)
            FAN_SPINUP: if (s.el >= P_FAN - 1) n = fok ? enter(G1_WAIT, NONE, s.retry) : enter(FAULT, FAN, s.retry);
            G1_WAIT: begin
              if (gok) n = enter(CA_RAMP, NONE, s.retry);
              else if (s.el >= P_G1 - 1) n = enter(FAULT, G1, s.retry);
            end
            CA_RAMP: if (s.el >= P_CA - 1) n = cok ? enter(RUN, NONE, s.retry) : enter(FAULT, CA, s.retry);
            RUN: if (!cok) n = enter(FAULT, CA, s.retry);
            SHUTDOWN: if (s.el >= P_COOL - 1) n = enter(IDLE, NONE, s.retry);
            default: n = s;
          endcase
        end
      end
    endcase
`ifdef RPSC_AUTO_RETRY_EN
    if ((n.ph == RUN) && (s.ph != RUN)) n.retry = 2'd0;
    if (clr) n.retry = 2'd0;
`else
    n.retry = 2'd0;
`endif
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= enter(IDLE, NONE, 2'd0);
    else m <= m_step(m, bus.start_req, bus.stop_req, bus.fault_clr, bus.not_alarm,
                     bus.fan_ok, bus.g1_ok, bus.ca_ok);
  end

  // Cycle-by-cycle comparison against the model, sampled well after the active edge.
  always @(posedge clk) begin
    #4;
    if (rst_n && chk_en) begin
      cmp("m_state", 8'(bus.state), 8'(m.ph));
      cmp("m_fan_on", 8'(bus.fan_on),
          8'((m.ph inside {FAN_SPINUP, G1_WAIT, CA_RAMP, RUN, SHUTDOWN}) || ((m.ph == FAULT) && (m.el < P_COOL))));
      cmp("m_g1_en", 8'(bus.g1_en), 8'(m.ph inside {G1_WAIT, CA_RAMP, RUN}));
      cmp("m_ca_ps_act", 8'(bus.ca_ps_act), 8'(m.ph inside {CA_RAMP, RUN}));
      cmp("m_running", 8'(bus.running), 8'(m.ph == RUN));
      cmp("m_fault", 8'(bus.fault), 8'(m.ph == FAULT));
      cmp("m_fault_code", 8'(bus.fault_code), 8'(m.code));
      cmp("m_retry_cnt", 8'(bus.retry_cnt), 8'(m.retry));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.start_req = 1'b0; bus.stop_req = 1'b0; bus.fault_clr = 1'b0;
    bus.not_alarm = 1'b1; bus.fan_ok = 1'b1; bus.g1_ok = 1'b1; bus.ca_ok = 1'b1;
    #1;
    cmp("rst_state", 8'(bus.state), 8'd0);
    cmp("rst_fan_on", 8'(bus.fan_on), 8'd0);
    cmp("rst_fault_code", 8'(bus.fault_code), 8'd0);
    cyc(2);
    rst_n = 1'b1; chk_en = 1'b1;

    // nominal power-up
    cyc(1); bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cmp("nom_fan_on_p1", 8'(bus.fan_on), 8'd1);
    cmp("nom_g1_en_p1", 8'(bus.g1_en), 8'd0);
    cyc(3); cmp("nom_g1_en_p4", 8'(bus.g1_en), 8'd0);
    cyc(1); cmp("nom_g1_en_p5", 8'(bus.g1_en), 8'd1);
    cmp("nom_ca_act_p5", 8'(bus.ca_ps_act), 8'd0);
    cyc(1); cmp("nom_ca_act_p6", 8'(bus.ca_ps_act), 8'd1);
    cyc(5); cmp("nom_running_p11", 8'(bus.running), 8'd0);
    cyc(1); cmp("nom_running_p12", 8'(bus.running), 8'd1);
    cmp("nom_state_run", 8'(bus.state), 8'd4);

    // orderly stop, then restart
    bus.stop_req = 1'b1;
    cyc(1); bus.stop_req = 1'b0;
    cmp("stop_state", 8'(bus.state), 8'd5);
    cmp("stop_g1_en", 8'(bus.g1_en), 8'd0);
    cyc(4); cmp("stop_fan_s5", 8'(bus.fan_on), 8'd1);
    cyc(1); cmp("stop_fan_s6", 8'(bus.fan_on), 8'd0);
    cmp("stop_idle", 8'(bus.state), 8'd0);
    bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cyc(11); cmp("restart_running", 8'(bus.running), 8'd1);

    // alarm and stop together in RUN: alarm wins
    bus.not_alarm = 1'b0; bus.stop_req = 1'b1;
    cyc(1); bus.not_alarm = 1'b1; bus.stop_req = 1'b0;
    cmp("alarm_state", 8'(bus.state), 8'd6);
    cmp("alarm_code", 8'(bus.fault_code), 8'd1);
    cmp("alarm_fan_on", 8'(bus.fan_on), 8'd1);
    cmp("alarm_g1_en", 8'(bus.g1_en), 8'd0);
    cmp("alarm_ca_act", 8'(bus.ca_ps_act), 8'd0);
    cyc(5); bus.fault_clr = 1'b1;
    cyc(1); bus.fault_clr = 1'b0;
    cmp("alarm_clr_idle", 8'(bus.state), 8'd0);

    // fan never confirms
    bus.fan_ok = 1'b0; bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cyc(4); cmp("fanf_code", 8'(bus.fault_code), 8'd2);
    cmp("fanf_fault", 8'(bus.fault), 8'd1);
    cyc(2); bus.fault_clr = 1'b1;
    cyc(1); bus.fault_clr = 1'b0;
    cmp("fanf_early_clr_ignored", 8'(bus.state), 8'd6);
    cyc(1); cmp("fanf_fan_on_5th", 8'(bus.fan_on), 8'd1);
    cyc(1); cmp("fanf_fan_off", 8'(bus.fan_on), 8'd0);
    bus.fault_clr = 1'b1;
    cyc(1); bus.fault_clr = 1'b0;
    cmp("fanf_clr_idle", 8'(bus.state), 8'd0);
    cmp("fanf_clr_code", 8'(bus.fault_code), 8'd0);
    bus.fan_ok = 1'b1;

    // asynchronous reset in the middle of CA ramp
    bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cyc(6); cmp("rmid_state_ca", 8'(bus.state), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    cmp("rmid_fan_on", 8'(bus.fan_on), 8'd0);
    cmp("rmid_g1_en", 8'(bus.g1_en), 8'd0);
    cmp("rmid_ca_act", 8'(bus.ca_ps_act), 8'd0);
    cmp("rmid_state", 8'(bus.state), 8'd0);
    cyc(1); rst_n = 1'b1;
    cyc(1); cmp("rmid_after_idle", 8'(bus.state), 8'd0);

    // G1 never regulates
    bus.g1_ok = 1'b0; bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cyc(7); cmp("g1f_code", 8'(bus.fault_code), 8'd3);
    bus.g1_ok = 1'b1;
    cyc(4); bus.fault_clr = 1'b1;
    cyc(1); bus.fault_clr = 1'b0;
    cmp("g1f_clr_idle", 8'(bus.state), 8'd0);

    // CA never regulates
    bus.ca_ok = 1'b0; bus.start_req = 1'b1;
    cyc(1); bus.start_req = 1'b0;
    cyc(120);
    cmp("caf_state", 8'(bus.state), 8'd6);
    cmp("caf_code", 8'(bus.fault_code), 8'd4);
    cmp("caf_fan_on", 8'(bus.fan_on), 8'd0);
`ifdef RPSC_AUTO_RETRY_EN
    cmp("caf_retry_cnt", 8'(bus.retry_cnt), 8'd3);
`else
    cmp("caf_retry_cnt", 8'(bus.retry_cnt), 8'd0);
`endif
    bus.ca_ok = 1'b1; bus.fault_clr = 1'b1;
    cyc(1); bus.fault_clr = 1'b0;
    cmp("caf_clr_idle", 8'(bus.state), 8'd0);
    cmp("caf_clr_retry", 8'(bus.retry_cnt), 8'd0);
    cyc(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
